// File: rtl/ula_arbitro.sv
// ula_arbitro
// Shares one combinational ULA between two requesters. Each requester
// offers an operation on a valid/ready channel. It gets its result back on
// a valid/ready response channel.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester operation handshake (bit i = requester i)
//   req_sel*/req_a*/req_b* operation code and operands for requester 0 / 1
//   resp_valid/resp_ready per-requester result handshake
//   resp_data, resp_err   result and division-by-zero flag for the owner
//   ula_sel/ula_a/ula_b   registered operands driven into the ULA
//   ula_saida             ULA result
//   ocupado               high whenever the sequencer is not idle
//   cont_ops              number of completed responses (wraps)
//
// Timing: an accept at edge N gives resp_valid from edge N+LAT+1. The first
// EXEC cycle lets the freshly registered operands propagate through the ULA.
// After that, the settle counter (loaded with LAT-1) counts down to zero.
module ula_arbitro #(
  parameter int LAT    = 1,
  parameter int CONT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req_sel0,
  input  logic [3:0]        req_sel1,
  input  logic [1:0]        req_a0,
  input  logic [1:0]        req_a1,
  input  logic              req_b0,
  input  logic              req_b1,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [2:0]        resp_data,
  output logic              resp_err,
  output logic [3:0]        ula_sel,
  output logic [1:0]        ula_a,
  output logic              ula_b,
  input  logic [2:0]        ula_saida,
  output logic              ocupado,
  output logic [CONT_W-1:0] cont_ops
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0]        CNT_LOAD = 4'(LAT - 1);
  localparam logic [3:0]        SEL_DIV  = 4'b0011;
  localparam logic [CONT_W-1:0] CONT_ONE = CONT_W'(1);

  state_t            state_q, state_d;
  logic              dono_q, dono_d;
  logic              ultimo_q, ultimo_d;
  logic              lanc_q, lanc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        ula_sel_q, ula_sel_d;
  logic [1:0]        ula_a_q, ula_a_d;
  logic              ula_b_q, ula_b_d;
  logic [1:0]        resp_valid_q, resp_valid_d;
  logic [2:0]        resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic [CONT_W-1:0] cont_q, cont_d;
  logic              ocupado_q, ocupado_d;

  logic              gnt_any;
  logic              gnt_idx;

  // Round-robin grant. On contention the requester that was not served
  // last wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 1'b0;
    if (state_q == IDLE) begin
      case (req_valid)
        2'b01: begin
          gnt_any = 1'b1;
          gnt_idx = 1'b0;
        end
        2'b10: begin
          gnt_any = 1'b1;
          gnt_idx = 1'b1;
        end
        2'b11: begin
          gnt_any = 1'b1;
          gnt_idx = ~ultimo_q;
        end
        default: begin
          gnt_any = 1'b0;
          gnt_idx = 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = gnt_any && (gnt_idx == 1'(gi));
  end

  always_comb begin
    state_d      = state_q;
    dono_d       = dono_q;
    ultimo_d     = ultimo_q;
    lanc_d       = lanc_q;
    cnt_d        = cnt_q;
    ula_sel_d    = ula_sel_q;
    ula_a_d      = ula_a_q;
    ula_b_d      = ula_b_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    cont_d       = cont_q;

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          dono_d    = gnt_idx;
          ula_sel_d = gnt_idx ? req_sel1 : req_sel0;
          ula_a_d   = gnt_idx ? req_a1 : req_a0;
          ula_b_d   = gnt_idx ? req_b1 : req_b0;
          cnt_d     = CNT_LOAD;
          lanc_d    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (lanc_q) begin
          lanc_d = 1'b0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Division by zero is trapped here. The ULA's own output is
          // not trusted for that case.
          if ((ula_sel_q == SEL_DIV) && !ula_b_q) begin
            resp_data_d = 3'b111;
            resp_err_d  = 1'b1;
          end else begin
            resp_data_d = ula_saida;
            resp_err_d  = 1'b0;
          end
          resp_valid_d = dono_q ? 2'b10 : 2'b01;
          state_d      = RESP;
        end
      end
      RESP: begin
        // Only the owner's ready bit completes the response.
        if (resp_ready[dono_q]) begin
          resp_valid_d = 2'b00;
          ultimo_d     = dono_q;
          cont_d       = cont_q + CONT_ONE;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ocupado_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dono_q       <= 1'b0;
      ultimo_q     <= 1'b1;
      lanc_q       <= 1'b0;
      cnt_q        <= 4'd0;
      ula_sel_q    <= 4'd0;
      ula_a_q      <= 2'd0;
      ula_b_q      <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= 3'd0;
      resp_err_q   <= 1'b0;
      cont_q       <= '0;
      ocupado_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dono_q       <= dono_d;
      ultimo_q     <= ultimo_d;
      lanc_q       <= lanc_d;
      cnt_q        <= cnt_d;
      ula_sel_q    <= ula_sel_d;
      ula_a_q      <= ula_a_d;
      ula_b_q      <= ula_b_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      cont_q       <= cont_d;
      ocupado_q    <= ocupado_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign ula_sel    = ula_sel_q;
  assign ula_a      = ula_a_q;
  assign ula_b      = ula_b_q;
  assign ocupado    = ocupado_q;
  assign cont_ops   = cont_q;

endmodule

// File: tb/tb_ula_arbitro.sv
// Testbench for ula_arbitro. There are two instances: LAT=1 (index 0) and
// LAT=4 (index 1). Each instance drives a behavioural ULA. The expected
// results come from a reference model with these parts:
//   - round-robin from the last served requester
//   - division-by-zero trap rule
//   - latency formula
//   - completed-operation count
module tb_ula_arbitro;
  localparam int CONT_W = 8;
  localparam int LAT0   = 1;
  localparam int LAT1   = 4;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic              rst        [2];
  logic [1:0]        req_valid  [2];
  logic [1:0]        req_ready  [2];
  logic [3:0]        req_sel0   [2];
  logic [3:0]        req_sel1   [2];
  logic [1:0]        req_a0     [2];
  logic [1:0]        req_a1     [2];
  logic              req_b0     [2];
  logic              req_b1     [2];
  logic [1:0]        resp_valid [2];
  logic [1:0]        resp_ready [2];
  logic [2:0]        resp_data  [2];
  logic              resp_err   [2];
  logic [3:0]        ula_sel    [2];
  logic [1:0]        ula_a      [2];
  logic              ula_b      [2];
  logic [2:0]        ula_saida  [2];
  logic              ocupado    [2];
  logic [CONT_W-1:0] cont_ops   [2];

  int n_chk  = 0;
  int n_pass = 0;
  int last_srv [2];
  int cont_m   [2];

  // Behavioural ULA standing in for the real one.
  function automatic logic [2:0] ula_f(input logic [3:0] s, input logic [1:0] a, input logic b);
    logic [2:0] ax, bx, r;
    ax = {1'b0, a};
    bx = {2'b00, b};
    case (s)
      4'd0:    r = ax + bx;
      4'd1:    r = ax - bx;
      4'd2:    r = ax * bx;
      4'd3:    r = b ? ax : 3'b000;
      4'd4:    r = ax & bx;
      4'd5:    r = ax | bx;
      4'd6:    r = ax ^ bx;
      4'd7:    r = ~ax;
      default: r = ax | bx;
    endcase
    return r;
  endfunction

  assign ula_saida[0] = ula_f(ula_sel[0], ula_a[0], ula_b[0]);
  assign ula_saida[1] = ula_f(ula_sel[1], ula_a[1], ula_b[1]);

  ula_arbitro #(.LAT(LAT0), .CONT_W(CONT_W)) dut0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_sel0(req_sel0[0]), .req_sel1(req_sel1[0]),
    .req_a0(req_a0[0]), .req_a1(req_a1[0]),
    .req_b0(req_b0[0]), .req_b1(req_b1[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_data(resp_data[0]), .resp_err(resp_err[0]),
    .ula_sel(ula_sel[0]), .ula_a(ula_a[0]), .ula_b(ula_b[0]),
    .ula_saida(ula_saida[0]), .ocupado(ocupado[0]), .cont_ops(cont_ops[0])
  );

  ula_arbitro #(.LAT(LAT1), .CONT_W(CONT_W)) dut1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_sel0(req_sel0[1]), .req_sel1(req_sel1[1]),
    .req_a0(req_a0[1]), .req_a1(req_a1[1]),
    .req_b0(req_b0[1]), .req_b1(req_b1[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_data(resp_data[1]), .resp_err(resp_err[1]),
    .ula_sel(ula_sel[1]), .ula_a(ula_a[1]), .ula_b(ula_b[1]),
    .ula_saida(ula_saida[1]), .ocupado(ocupado[1]), .cont_ops(cont_ops[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One full transaction on instance k.
  // The caller must be at a falling edge. The task returns at the falling
  // edge just after the response handshake. At that point the sequencer is
  // idle again, so the next call can be granted in that same idle cycle.
  task automatic run_op(input int k, input logic [1:0] vm, input logic [1:0] vm_after,
                        input logic [3:0] s0, input logic [1:0] x0, input logic y0,
                        input logic [3:0] s1, input logic [1:0] x1, input logic y1,
                        input int hold);
    int         g, lat;
    logic [1:0] own;
    logic [3:0] es;
    logic [1:0] ea;
    logic       eb, ee;
    logic [2:0] ed;
    req_valid[k]  = vm;
    req_sel0[k]   = s0; req_a0[k] = x0; req_b0[k] = y0;
    req_sel1[k]   = s1; req_a1[k] = x1; req_b1[k] = y1;
    resp_ready[k] = 2'b00;
    #1;
    g   = (vm == 2'b11) ? (1 - last_srv[k]) : int'(vm[1]);
    own = (g == 1) ? 2'b10 : 2'b01;
    chk("grant", 32'(req_ready[k]), 32'(own));
    es = (g == 1) ? s1 : s0;
    ea = (g == 1) ? x1 : x0;
    eb = (g == 1) ? y1 : y0;
    ee = (es == 4'b0011) && !eb;
    ed = ee ? 3'b111 : ula_f(es, ea, eb);

    @(posedge clk);  // accept edge
    @(negedge clk);
    // Later request changes must not disturb the captured operation.
    req_valid[k] = vm_after;
    req_sel0[k] = 4'($urandom); req_a0[k] = 2'($urandom); req_b0[k] = 1'($urandom);
    req_sel1[k] = 4'($urandom); req_a1[k] = 2'($urandom); req_b1[k] = 1'($urandom);
    lat = 0;
    #1;
    while (resp_valid[k] == 2'b00 && lat < 40) begin
      chk("exec_sel", 32'(ula_sel[k]), 32'(es));
      chk("exec_a", 32'(ula_a[k]), 32'(ea));
      chk("exec_b", 32'(ula_b[k]), 32'(eb));
      chk("exec_busy", 32'(ocupado[k]), 32'd1);
      chk("exec_ready", 32'(req_ready[k]), 32'd0);
      @(posedge clk);
      lat++;
      @(negedge clk);
      #1;
    end
    chk("latency", 32'(lat), 32'(lat_of(k) + 1));
    chk("resp_valid", 32'(resp_valid[k]), 32'(own));
    chk("resp_data", 32'(resp_data[k]), 32'(ed));
    chk("resp_err", 32'(resp_err[k]), 32'(ee));

    // The non-owner's ready bit must be ignored.
    resp_ready[k] = ~own;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("hold_valid", 32'(resp_valid[k]), 32'(own));
      chk("hold_data", 32'(resp_data[k]), 32'(ed));
      chk("hold_err", 32'(resp_err[k]), 32'(ee));
      chk("hold_ready", 32'(req_ready[k]), 32'd0);
      chk("hold_busy", 32'(ocupado[k]), 32'd1);
    end

    resp_ready[k] = own;
    @(posedge clk);  // response handshake
    @(negedge clk);
    last_srv[k] = g;
    cont_m[k]   = (cont_m[k] + 1) % (1 << CONT_W);
    chk("done_valid", 32'(resp_valid[k]), 32'd0);
    chk("done_busy", 32'(ocupado[k]), 32'd0);
    chk("cont_ops", 32'(cont_ops[k]), 32'(cont_m[k]));
    resp_ready[k] = 2'b00;
    $display("op inst=%0d grant=%0d sel=%0h a=%0d b=%0d data=%0d err=%0d lat=%0d cont=%0d",
             k, g, es, ea, eb, resp_data[k], resp_err[k], lat, cont_ops[k]);
  endtask

  task automatic run_random(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      run_op(k, 2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
             4'($urandom), 2'($urandom), 1'($urandom),
             4'($urandom), 2'($urandom), 1'($urandom),
             $urandom_range(0, 3));
    end
    req_valid[k] = 2'b00;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k]        = 1'b1;
      req_valid[k]  = 2'b00;
      req_sel0[k]   = 4'd0; req_a0[k] = 2'd0; req_b0[k] = 1'b0;
      req_sel1[k]   = 4'd0; req_a1[k] = 2'd0; req_b1[k] = 1'b0;
      resp_ready[k] = 2'b00;
      last_srv[k]   = 1;
      cont_m[k]     = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", 32'(resp_valid[k]), 32'd0);
      chk("rst_data", 32'(resp_data[k]), 32'd0);
      chk("rst_err", 32'(resp_err[k]), 32'd0);
      chk("rst_sel", 32'(ula_sel[k]), 32'd0);
      chk("rst_a", 32'(ula_a[k]), 32'd0);
      chk("rst_b", 32'(ula_b[k]), 32'd0);
      chk("rst_busy", 32'(ocupado[k]), 32'd0);
      chk("rst_cont", 32'(cont_ops[k]), 32'd0);
      chk("rst_ready", 32'(req_ready[k]), 32'd0);
    end

    // Single request: 3 + 1 = 4.
    run_op(0, 2'b01, 2'b00, 4'b0000, 2'd3, 1'b1, 4'd0, 2'd0, 1'b0, 0);
    chk("first_data", 32'(resp_data[0]), 32'd4);  // still held after handshake
    // Both requesters valid on every cycle: strict alternation.
    repeat (4) run_op(0, 2'b11, 2'b11, 4'b0010, 2'd3, 1'b1, 4'b1111, 2'd1, 1'b1, 1);
    // Division by zero, then a legal division.
    run_op(0, 2'b10, 2'b00, 4'd0, 2'd0, 1'b0, 4'b0011, 2'd2, 1'b0, 0);
    run_op(0, 2'b10, 2'b00, 4'd0, 2'd0, 1'b0, 4'b0011, 2'd2, 1'b1, 0);
    // Long stall with requester 1 waiting. It is served right after.
    run_op(0, 2'b01, 2'b10, 4'b0001, 2'd0, 1'b1, 4'd0, 2'd0, 1'b0, 10);
    run_op(0, 2'b10, 2'b00, 4'd0, 2'd0, 1'b0, 4'b0110, 2'd3, 1'b1, 0);
    run_random(0, 20);

    // LAT=4 instance.
    run_op(1, 2'b01, 2'b00, 4'b0000, 2'd2, 1'b1, 4'd0, 2'd0, 1'b0, 0);
    run_random(1, 20);

    // Reset while in EXEC: abort, no response, requester 0 wins next.
    req_valid[1] = 2'b01;
    req_sel0[1] = 4'b0001; req_a0[1] = 2'd2; req_b0[1] = 1'b1;
    #1;
    chk("abort_grant", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 2'b00;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("abort_busy", 32'(ocupado[1]), 32'd1);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    last_srv[1] = 1;
    cont_m[1]   = 0;
    chk("abort_idle", 32'(ocupado[1]), 32'd0);
    chk("abort_valid", 32'(resp_valid[1]), 32'd0);
    chk("abort_cont", 32'(cont_ops[1]), 32'd0);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("abort_noresp", 32'(resp_valid[1]), 32'd0);
    end
    run_op(1, 2'b11, 2'b00, 4'b0101, 2'd1, 1'b0, 4'b0100, 2'd3, 1'b1, 0);
    req_valid[1] = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
